// File: rtl/matvec_pkg.sv
// Shared widths, types and the round/shift/saturate helper for the matrix-vector unit.
package matvec_pkg;

    localparam int unsigned ACC_WIDTH  = 28;
    localparam int unsigned DATA_WIDTH = 14;
    localparam int unsigned MAT_SIZE   = 3;

    typedef logic signed [ACC_WIDTH-1:0]  acc_t;
    typedef logic signed [DATA_WIDTH-1:0] data_t;

    typedef struct packed {
        data_t data;
        logic  clamp;
    } sat_res_t;

    localparam int DataMax = 2 ** (DATA_WIDTH - 1) - 1;
    localparam int DataMin = -(2 ** (DATA_WIDTH - 1));

    // Round half-up (toward +inf) before the arithmetic shift; one guard bit avoids overflow.
    function automatic sat_res_t sat_round(input acc_t acc, input int unsigned shift);
        logic signed [ACC_WIDTH:0] t;
        logic signed [ACC_WIDTH:0] q;
        logic signed [ACC_WIDTH:0] hi;
        logic signed [ACC_WIDTH:0] lo;
        sat_res_t                  r;
        hi = (ACC_WIDTH + 1)'(DataMax);
        lo = (ACC_WIDTH + 1)'(DataMin);
        t  = {acc[ACC_WIDTH-1], acc};
        if (shift > 0) begin
            t = t + ((ACC_WIDTH + 1)'(1) << (shift - 1));
        end
        q       = t >>> shift;
        r.clamp = 1'b1;
        if (q > hi) begin
            r.data = hi[DATA_WIDTH-1:0];
        end else if (q < lo) begin
            r.data = lo[DATA_WIDTH-1:0];
        end else begin
            r.data  = q[DATA_WIDTH-1:0];
            r.clamp = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO with count register; reads as zero when empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign valid_o = (cnt_q != '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && valid_o;
    assign rdata_o = valid_o ? mem_q[rptr_q] : '0;

    always_comb begin
        wptr_d = wptr_q + PtrW'(do_push);
        rptr_d = rptr_q + PtrW'(do_pop);
        cnt_d  = cnt_q;
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/matvec_out_quant.sv
// Output quantizer for the 3x3 matrix-vector unit: round, shift, saturate, frame and buffer.
// Optional ReLU after saturation when MATVEC_OUT_RELU_EN is defined.
module matvec_out_quant
    import matvec_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = ACC_WIDTH,
    parameter int unsigned OUT_WIDTH  = DATA_WIDTH,
    parameter int unsigned SHIFT      = 7,
    parameter int unsigned ROWS       = MAT_SIZE,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 sat_seen
);

    if (IN_WIDTH != ACC_WIDTH || OUT_WIDTH != DATA_WIDTH) begin : g_width_check
        $error("matvec_out_quant widths must match matvec_pkg types");
    end

    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [RowW-1:0]    row_q, row_d;
    logic               sat_q, sat_d;
    logic               full, accept, last_in;
    sat_res_t           qr;
    data_t              q_data;
    logic [OUT_WIDTH:0] fifo_rdata;

    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign last_in  = (row_q == RowW'(ROWS - 1));

    always_comb begin
        qr     = sat_round(acc_t'(in_data), SHIFT);
        q_data = qr.data;
`ifdef MATVEC_OUT_RELU_EN
        if (q_data[DATA_WIDTH-1]) begin
            q_data = '0;
        end
`endif
    end

    always_comb begin
        row_d = row_q;
        sat_d = sat_q;
        if (accept) begin
            row_d = last_in ? '0 : row_q + 1'b1;
            if (qr.clamp) begin
                sat_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            sat_q <= 1'b0;
        end else begin
            row_q <= row_d;
            sat_q <= sat_d;
        end
    end

    sync_fifo #(
        .WIDTH(OUT_WIDTH + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .reset_i(reset),
        .push_i (accept),
        .wdata_i({last_in, q_data}),
        .full_o (full),
        .pop_i  (out_ready),
        .valid_o(out_valid),
        .rdata_o(fifo_rdata)
    );

    assign out_data = fifo_rdata[OUT_WIDTH-1:0];
    assign out_last = fifo_rdata[OUT_WIDTH];
    assign sat_seen = sat_q;

endmodule

// File: tb/tb_matvec_out_quant.sv
// Directed-vector bench for matvec_out_quant (SHIFT=7, ROWS=3, FIFO_DEPTH=4).
module tb_matvec_out_quant;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_data;
    logic        out_last;
    logic        sat_seen;

    int n_vec = 0;
    int n_err = 0;
    int row   = 0;
    int got_data[$];
    bit got_last[$];

    always #5 clk = ~clk;

    matvec_out_quant dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .sat_seen (sat_seen)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rl(input int v);
`ifdef MATVEC_OUT_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        row   = 0;
    endtask

    // One isolated result: accept, check presentation one cycle later, then pop.
    task automatic single(input string tag, input int d, input int exp_d, input int exp_sat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = 28'(d);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, $signed(out_data), exp_d);
        check({tag, "_last"}, out_last, (row == 2) ? 1 : 0);
        check({tag, "_sat"}, sat_seen, exp_sat);
        row       = (row + 1) % 3;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drained"}, out_valid, 0);
    endtask

    // Streams (base+i)*128 for i < n_in and records every output handshake.
    task automatic run_collect(input int n_in, input int base, input int exp_n, input logic rdy);
        int sent = 0;
        int cyc  = 0;
        got_data.delete();
        got_last.delete();
        while ((sent < n_in || got_data.size() < exp_n) && cyc < 50) begin
            @(negedge clk);
            cyc++;
            out_ready = rdy;
            if (out_valid && out_ready) begin
                got_data.push_back(int'($signed(out_data)));
                got_last.push_back(out_last);
            end
            if (sent < n_in) begin
                in_valid = 1'b1;
                in_data  = 28'((base + sent) * 128);
                if (in_ready) sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("collect_done", (sent == n_in && got_data.size() >= exp_n) ? 1 : 0, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int first, input int n, input int row0);
        check({tag, "_count"}, got_data.size(), n);
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), got_data[i], first + i);
            check($sformatf("%s_last%0d", tag, i), got_last[i], ((row0 + i) % 3 == 2) ? 1 : 0);
        end
    endtask

    initial begin
        do_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", $signed(out_data), 0);
        check("rst_out_last", out_last, 0);
        check("rst_sat", sat_seen, 0);

        single("exact", 4736, 37, 0);
        single("rnd_p192", 192, 2, 0);
        single("rnd_m192", -192, rl(-1), 0);
        single("rnd_63", 63, 0, 0);
        single("rnd_64", 64, 1, 0);
        single("sat_max", 134217727, 8191, 1);
        single("sat_min", -134217728, rl(-8192), 1);
        single("neg300", -300, rl(-2), 1);
        single("pos300", 300, 2, 1);

        // Backpressure: fill the FIFO, hold a fifth result, then drain in order.
        do_reset();
        run_collect(4, 1, 0, 1'b0);
        @(negedge clk);
        check("bp_full_ready", in_ready, 0);
        check("bp_full_valid", out_valid, 1);
        check("bp_head", $signed(out_data), 1);
        in_valid = 1'b1;
        in_data  = 28'(5 * 128);
        repeat (2) @(negedge clk);
        check("bp_hold_ready", in_ready, 0);
        check("bp_hold_head", $signed(out_data), 1);
        in_valid = 1'b0;
        run_collect(1, 5, 5, 1'b1);
        check_stream("drain", 1, 5, 0);
        @(negedge clk);
        check("drain_empty", out_valid, 0);

        do_reset();
        run_collect(6, 1, 6, 1'b1);
        check_stream("frame", 1, 6, 0);

        // Reset mid-stream flushes buffered entries and restarts framing.
        do_reset();
        run_collect(2, 1, 0, 1'b0);
        @(negedge clk);
        check("flush_pre_valid", out_valid, 1);
        do_reset();
        check("flush_valid", out_valid, 0);
        check("flush_data", $signed(out_data), 0);
        check("flush_last", out_last, 0);
        run_collect(3, 1, 3, 1'b1);
        check_stream("post_rst", 1, 3, 0);
        @(negedge clk);
        check("post_rst_empty", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

endmodule
